dmem_arbiter: RTL

- Shares the single data-memory port between the core load/store path and a program/data loader (testbench or boot DMA).
- Only one access per cycle. Fair round-robin on contention, with a bounded burst lock for the loader.
- Produces a stall for the core whenever its request is not granted, so the PC register and register-file write can be held.
- Sits between the core LSU signals (ALU address, rs2 data, MemRead/MemWrite) and the data memory.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory arbiter and its round-robin picker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // Requester identity, used for last_winner and read-return ownership.
    typedef enum logic {
        CORE = 1'b0,
        LDR  = 1'b1
    } owner_t;

    // Arbiter mode: plain round-robin, or loader holding a burst lock.
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int                  BURST_W   = 8;
    localparam logic [BURST_W-1:0]  BURST_SAT = 8'hFF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core LSU, loader and data-memory signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: grant/stall outputs tell each requester whether it was served.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic              ldr_lock;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus memory, i.e. everything around the arbiter.
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; req[0]/gnt[0] is the CORE slot, [1] the LDR slot.
// Latency: combinational grant; last_winner updates on the clock edge after a grant.
// Backpressure: a single request always wins; on a tie the side that did not win last wins.
module rr_arb2 import riscv_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  owner_t     upd_owner,
    output logic [1:0] gnt
);

    owner_t last_winner;

    // Tie goes to whoever did not win most recently.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_winner == LDR) ? 2'b01 : 2'b10;
        end
    end

    // Remember the actual winner; the caller may override the pick (burst lock).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner <= LDR;
        end else if (upd) begin
            last_winner <= upd_owner;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between core LSU and loader, with a bounded loader burst lock.
// Latency: grant and memory strobe same cycle as request; read data one cycle later.
// Backpressure: ungranted core request raises core_stall; ungranted loader just sees ldr_gnt=0.
module dmem_arbiter import riscv_pkg::*; #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

    arb_state_t         state, state_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
    logic               rd_pending;
    owner_t             rd_owner;

    logic [1:0]         rr_gnt;
    logic               ldr_hold;
    logic               core_gnt, ldr_gnt, mem_en;
    logic               we_sel;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  wdata_sel;
    owner_t             winner;

    assign ldr_hold = bus.ldr_req & bus.ldr_lock;
    assign mem_en   = core_gnt | ldr_gnt;
    assign winner   = ldr_gnt ? LDR : CORE;

    rr_arb2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       ({bus.ldr_req, bus.core_req}),
        .upd       (mem_en),
        .upd_owner (winner),
        .gnt       (rr_gnt)
    );

    // Grant selection: locked loader keeps the port until it drops the lock or the waiting core hits the burst limit.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        core_gnt      = 1'b0;
        ldr_gnt       = 1'b0;
        if (state == LOCKED && ldr_hold && (!bus.core_req || burst_cnt < MAX_CNT)) begin
            ldr_gnt = 1'b1;
            // Only cycles in which the core is kept waiting use up the burst budget.
            if (bus.core_req && burst_cnt != BURST_SAT) begin
                burst_cnt_nxt = burst_cnt + BURST_W'(1);
            end
        end else if (state == LOCKED && ldr_hold) begin
            core_gnt      = 1'b1;
            state_nxt     = ARB;
            burst_cnt_nxt = '0;
        end else begin
            core_gnt = rr_gnt[0];
            ldr_gnt  = rr_gnt[1];
            if (ldr_gnt && bus.ldr_lock) begin
                state_nxt     = LOCKED;
                burst_cnt_nxt = BURST_W'(1);
            end else begin
                state_nxt     = ARB;
                burst_cnt_nxt = '0;
            end
        end
    end

    // Route the winner's access to memory; idle bus is driven to zero.
    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (ldr_gnt) begin
            we_sel    = bus.ldr_we;
            addr_sel  = bus.ldr_addr;
            wdata_sel = bus.ldr_wdata;
        end else if (core_gnt) begin
            we_sel    = bus.core_we;
            addr_sel  = bus.core_addr;
            wdata_sel = bus.core_wdata;
        end
    end

    // Arbiter mode and burst counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Track who owns the read returning next cycle; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= CORE;
        end else begin
            rd_pending <= mem_en & ~we_sel;
            if (mem_en && !we_sel) begin
                rd_owner <= winner;
            end
        end
    end

    assign bus.core_gnt    = core_gnt;
    assign bus.ldr_gnt     = ldr_gnt;
    assign bus.core_stall  = bus.core_req & ~core_gnt;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = we_sel;
    assign bus.mem_addr    = addr_sel;
    assign bus.mem_wdata   = wdata_sel;
    assign bus.core_rvalid = rd_pending & (rd_owner == CORE);
    assign bus.ldr_rvalid  = rd_pending & (rd_owner == LDR);
    assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
    assign bus.ldr_rdata   = bus.ldr_rvalid  ? bus.mem_rdata : '0;

endmodule
